weight_fetch_sequencer: RTL and testbench

WEIGHT_FETCH_SEQUENCER -- requirements
Module: weight_fetch_sequencer

---
 rtl/weight_fetch_sequencer.sv | 107 ++++++++++
 tb/tb_weight_fetch_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/weight_fetch_sequencer.sv
// Weight fetch sequencer: pairs streamed activations with weights
// read from a registered weight memory, one pair per accepted input.
module weight_fetch_sequencer #(
  parameter int numWeight    = 30,
  parameter int addressWidth = $clog2(numWeight),
  parameter int dataWidth    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    in_valid,
  input  logic [dataWidth-1:0]    in_data,
  output logic                    in_ready,
  output logic                    mem_ren,
  output logic [addressWidth-1:0] mem_radd,
  input  logic [dataWidth-1:0]    mem_rdata,
  output logic                    mac_valid,
  output logic [dataWidth-1:0]    mac_x,
  output logic [dataWidth-1:0]    mac_w,
  output logic                    mac_last,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [addressWidth-1:0] LastAddr =
    addressWidth'(numWeight - 1);

  state_t                  state_q, state_d;
  logic [addressWidth-1:0] addr_q, addr_d;
  logic                    mac_valid_q, mac_valid_d;
  logic                    mac_last_q, mac_last_d;
  logic [dataWidth-1:0]    mac_x_q, mac_x_d;
  logic                    issue;
  logic                    at_end;

  always_comb begin
    issue       = (state_q == RUN) && in_valid && !rst;
    at_end      = (addr_q == LastAddr);
    state_d     = state_q;
    addr_d      = addr_q;
    // abort still lets the read go out but suppresses the pair
    mac_valid_d = issue && !abort;
    mac_last_d  = issue && at_end && !abort;
    mac_x_d     = issue ? in_data : mac_x_q;
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      addr_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RUN;
            addr_d  = '0;
          end
        end
        RUN: begin
          if (issue) begin
            if (at_end) begin
              addr_d  = '0;
              state_d = DRAIN;
            end else begin
              addr_d = addr_q + 1'b1;
            end
          end
        end
        DRAIN:   state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      mac_valid_q <= 1'b0;
      mac_last_q  <= 1'b0;
      mac_x_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      mac_valid_q <= mac_valid_d;
      mac_last_q  <= mac_last_d;
      mac_x_q     <= mac_x_d;
    end
  end

  assign in_ready  = (state_q == RUN) && !rst;
  assign mem_ren   = issue;
  assign mem_radd  = rst ? '0 : addr_q;
  assign mac_valid = mac_valid_q;
  assign mac_last  = mac_last_q;
  assign mac_x     = mac_x_q;
  assign mac_w     = mem_rdata;
  assign busy      = (state_q != IDLE) && !rst;
  assign done      = (state_q == DONE) && !rst && !abort;

endmodule

// File: tb/tb_weight_fetch_sequencer.sv
// Bench for weight_fetch_sequencer: randomized directed sequences
// checked every cycle against a sequence-level reference model.
module tb_weight_fetch_sequencer;

  localparam int N  = 30;
  localparam int AW = $clog2(N);
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst, start, abort, in_valid;
  logic [DW-1:0] in_data, mem_rdata;
  logic          in_ready, mem_ren, mac_valid, mac_last, busy, done;
  logic [AW-1:0] mem_radd;
  logic [DW-1:0] mac_x, mac_w;

  weight_fetch_sequencer #(
    .numWeight(N),
    .addressWidth(AW),
    .dataWidth(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .mem_ren(mem_ren),
    .mem_radd(mem_radd),
    .mem_rdata(mem_rdata),
    .mac_valid(mac_valid),
    .mac_x(mac_x),
    .mac_w(mac_w),
    .mac_last(mac_last),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [N];

  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= mem[mem_radd];
  end

  int tests = 0;
  int fails = 0;

  // model: phase 0 idle, 1 accepting, 2 presenting last, 3 done
  int            ph;
  int            cnt;
  bit            exp_v, exp_l;
  logic [DW-1:0] exp_x, exp_w;
  int            obs_pairs;
  int            mdl_pairs;
  int            done_seen;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit a,
                     input bit v, input logic [DW-1:0] d);
    bit e_rdy, e_ren, e_busy, e_done, nv, lst;
    @(negedge clk);
    rst = r; start = s; abort = a; in_valid = v; in_data = d;
    #1;
    e_rdy  = !r && ph == 1;
    e_ren  = e_rdy && v;
    e_busy = !r && ph != 0;
    e_done = !r && ph == 3 && !a;
    chk("in_ready", 32'(in_ready), 32'(e_rdy));
    chk("mem_ren", 32'(mem_ren), 32'(e_ren));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    if (r) chk("rst_radd", 32'(mem_radd), 32'(0));
    if (e_ren) chk("mem_radd", 32'(mem_radd), 32'(cnt));
    chk("mac_valid", 32'(mac_valid), 32'(exp_v));
    if (exp_v) begin
      chk("mac_x", 32'(mac_x), 32'(exp_x));
      chk("mac_w", 32'(mac_w), 32'(exp_w));
      chk("mac_last", 32'(mac_last), 32'(exp_l));
    end
    if (mac_valid === 1'b1) obs_pairs++;
    if (e_done) begin
      done_seen++;
      chk("pair_count", 32'(obs_pairs), 32'(N));
      chk("model_pairs", 32'(mdl_pairs), 32'(N));
    end
    nv = 0;
    if (r) begin
      ph = 0; cnt = 0; exp_x = '0; exp_l = 0;
      obs_pairs = 0; mdl_pairs = 0;
    end else begin
      lst = (cnt == N - 1);
      if (e_ren) begin
        exp_x = d;
        exp_w = mem[cnt];
      end
      if (a && ph != 0) begin
        ph = 0; cnt = 0; obs_pairs = 0; mdl_pairs = 0;
      end else begin
        case (ph)
          0: if (s) begin ph = 1; cnt = 0; obs_pairs = 0; mdl_pairs = 0; end
          1: if (e_ren) begin
               nv = 1;
               exp_l = lst;
               mdl_pairs++;
               if (lst) begin ph = 2; cnt = 0; end
               else cnt++;
             end
          2: ph = 3;
          default: ph = 0;
        endcase
      end
    end
    exp_v = nv;
    if (!nv) exp_l = 0;
  endtask

  // vmode: 0 always valid, 1 toggling, 2 random; smode: 0 none, 1 random, 2 held
  task automatic run_seq(input int vmode, input int smode,
                         input int abort_at, input int rst_at);
    bit v, s;
    int k;
    cyc(0, 1, 0, 0, '0);
    k = 0;
    while (ph != 0 && k < 200) begin
      v = (vmode == 0) ? 1'b1 : (vmode == 1) ? bit'(k % 2 == 0)
                                            : bit'($urandom % 2);
      s = (smode == 2) ? 1'b1 : (smode == 1) ? bit'($urandom % 2) : 1'b0;
      if (ph == 1 && cnt == abort_at && v) cyc(0, s, 1, 1, DW'($urandom));
      else if (ph == 1 && cnt == rst_at && v) cyc(1, s, 0, 1, DW'($urandom));
      else cyc(0, s, 0, v, (vmode == 0) ? DW'(cnt + 100) : DW'($urandom));
      k++;
    end
    chk("seq_bound", 32'(ph), 32'(0));
  endtask

  initial begin
    rst = 1; start = 0; abort = 0; in_valid = 0; in_data = '0;
    ph = 0; cnt = 0; exp_v = 0; exp_l = 0; exp_x = '0; exp_w = '0;
    obs_pairs = 0; mdl_pairs = 0; done_seen = 0;
    for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
    cyc(1, 1, 1, 1, '1);
    cyc(1, 0, 0, 0, '0);
    cyc(0, 0, 0, 1, '0);
    chk("reset_mac_x", 32'(mac_x), 32'(0));
    chk("reset_mac_last", 32'(mac_last), 32'(0));

    run_seq(0, 0, -1, -1);
    cyc(0, 0, 0, 1, '0);
    run_seq(1, 0, -1, -1);
    run_seq(2, 0, -1, -1);

    run_seq(2, 0, 10, -1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, DW'($urandom));
    run_seq(0, 0, -1, -1);

    run_seq(2, 1, -1, -1);

    run_seq(2, 0, -1, 14);
    cyc(0, 0, 1, 1, '0);
    run_seq(0, 0, -1, -1);

    for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
    done_seen = 0;
    for (int j = 0; j < 3; j++) run_seq(2, 2, -1, -1);
    chk("b2b_done_count", 32'(done_seen), 32'(3));
    cyc(0, 0, 0, 0, '0);
    cyc(0, 0, 0, 0, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
